// File: rtl/apb_pkg.sv
// Shared APB completer types: FSM state encoding and wait-counter width.
package apb_pkg;

    localparam int unsigned APB_WAIT_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } apb_slv_state_t;

endpackage

// File: rtl/apb_regfile.sv
// Word-addressed register file: async clear, synchronous write, combinational read.
module apb_regfile #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned MEM_DEPTH  = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [MEM_DEPTH];

    // Address decode by comparison keeps unimplemented addresses from aliasing.
    always_comb begin
        mem_d = mem_q;
        for (int unsigned i = 0; i < MEM_DEPTH; i++) begin
            if (we && (waddr == ADDR_WIDTH'(i))) begin
                mem_d[i] = wdata;
            end
        end
    end

    always_comb begin
        rdata = '0;
        for (int unsigned i = 0; i < MEM_DEPTH; i++) begin
            if (raddr == ADDR_WIDTH'(i)) begin
                rdata = mem_q[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < MEM_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

endmodule

// File: rtl/apb_slave_mem.sv
// APB completer backed by a local register file, with programmable wait states
// and pslverr on addresses beyond the implemented depth.
module apb_slave_mem
    import apb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned ADDR_WIDTH  = 4,
    parameter int unsigned MEM_DEPTH   = 12,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic                  pclk,
    input  logic                  prst,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [DATA_WIDTH-1:0] pwdata,
    output logic [DATA_WIDTH-1:0] prdata,
    output logic                  pready,
    output logic                  pslverr
);

    if (WAIT_CYCLES > 15) begin : g_bad_wait
        $error("apb_slave_mem: WAIT_CYCLES must be 0..15");
    end
    if (MEM_DEPTH > (2 ** ADDR_WIDTH)) begin : g_bad_depth
        $error("apb_slave_mem: MEM_DEPTH exceeds address space");
    end

    localparam logic [APB_WAIT_W-1:0] WAIT_INIT = APB_WAIT_W'(WAIT_CYCLES);
    localparam logic [ADDR_WIDTH:0]   DEPTH_L   = (ADDR_WIDTH + 1)'(MEM_DEPTH);

    apb_slv_state_t        state_q, state_d;
    logic [APB_WAIT_W-1:0] cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  wr_q, wr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  pready_q, pready_d;
    logic                  pslverr_q, pslverr_d;
    logic [DATA_WIDTH-1:0] prdata_q, prdata_d;

    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  addr_ok;

    assign addr_ok = ({1'b0, addr_q} < DEPTH_L);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wr_d      = wr_q;
        wdata_d   = wdata_q;
        prdata_d  = prdata_q;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        mem_we    = 1'b0;
        case (state_q)
            IDLE: begin
                if (psel && !penable) begin
                    addr_d  = paddr;
                    wr_d    = pwrite;
                    wdata_d = pwdata;
                    cnt_d   = WAIT_INIT;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (!psel) begin
                    state_d = IDLE;
                end else if (penable) begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - APB_WAIT_W'(1);
                    end else begin
                        pready_d = 1'b1;
                        state_d  = DONE;
                        if (!addr_ok) begin
                            pslverr_d = 1'b1;
                            prdata_d  = '0;
                        end else if (wr_q) begin
                            mem_we = 1'b1;
                        end else begin
                            prdata_d = mem_rdata;
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge pclk or posedge prst) begin
        if (prst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            wr_q      <= 1'b0;
            wdata_q   <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wr_q      <= wr_d;
            wdata_q   <= wdata_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
        end
    end

    apb_regfile #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH)
    ) u_regfile (
        .clk   (pclk),
        .rst   (prst),
        .we    (mem_we),
        .waddr (addr_q),
        .wdata (wdata_q),
        .raddr (addr_q),
        .rdata (mem_rdata)
    );

    assign prdata  = prdata_q;
    assign pready  = pready_q;
    assign pslverr = pslverr_q;

endmodule

// File: tb/tb_apb_slave_mem.sv
// Directed bench for apb_slave_mem: vector table of single transfers plus
// hand-written abort, hold/ignored-change and mid-transfer reset sequences.
module tb_apb_slave_mem;

    localparam int unsigned WAIT = 1;

    logic        pclk = 1'b0;
    logic        prst;
    logic        psel, penable, pwrite;
    logic [3:0]  paddr;
    logic [15:0] pwdata;
    logic [15:0] prdata;
    logic        pready, pslverr;

    int errors = 0;
    int checks = 0;

    always #5 pclk = ~pclk;

    apb_slave_mem #(
        .DATA_WIDTH  (16),
        .ADDR_WIDTH  (4),
        .MEM_DEPTH   (12),
        .WAIT_CYCLES (WAIT)
    ) dut (
        .pclk    (pclk),
        .prst    (prst),
        .psel    (psel),
        .penable (penable),
        .pwrite  (pwrite),
        .paddr   (paddr),
        .pwdata  (pwdata),
        .prdata  (prdata),
        .pready  (pready),
        .pslverr (pslverr)
    );

    typedef struct {
        logic        wr;
        logic [3:0]  addr;
        logic [15:0] wdata;
        logic [15:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic wr, input logic [3:0] a, input logic [15:0] wd,
                           input logic [15:0] er, input logic ee);
        vec_t v;
        v.wr = wr; v.addr = a; v.wdata = wd; v.exp_rdata = er; v.exp_err = ee;
        vecs.push_back(v);
    endtask

    // Called #1 after a rising edge. lat counts edges after the SETUP edge up to
    // the edge at which pready rises (hold edges with penable=0 included).
    task automatic xfer(input logic wr, input logic [3:0] a, input logic [15:0] wd,
                        input int hold, input bit corrupt,
                        output logic [15:0] rd, output logic er, output int lat);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd;
        @(posedge pclk); #1;
        if (corrupt) begin
            paddr = a ^ 4'h1; pwdata = ~wd; pwrite = ~wr;
        end
        lat = 0;
        repeat (hold) begin
            @(posedge pclk); #1;
            chk("pready_during_hold", {31'b0, pready}, 32'd0);
            lat++;
        end
        penable = 1'b1;
        while (!pready && lat < 40) begin
            @(posedge pclk); #1;
            lat++;
        end
        if (!pready) begin
            checks++;
            errors++;
            $display("FAIL timeout: pready not seen after %0d edges, required within %0d", lat, hold + WAIT + 1);
        end
        rd = prdata;
        er = pslverr;
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0;
        chk("pready_one_cycle", {31'b0, pready}, 32'd0);
        chk("pslverr_clears", {31'b0, pslverr}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required to finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] rd;
        logic        er;
        int          lat;
        int          seen;

        add_vec(1, 4'd3,  16'hA5A5, 16'h0000, 0);
        add_vec(0, 4'd3,  16'h0000, 16'hA5A5, 0);
        add_vec(0, 4'd5,  16'h0000, 16'h0000, 0);
        add_vec(0, 4'd1,  16'h0000, 16'h0000, 0);
        add_vec(1, 4'd13, 16'hDEAD, 16'h0000, 1);
        add_vec(0, 4'd13, 16'h0000, 16'h0000, 1);
        add_vec(0, 4'd3,  16'h0000, 16'hA5A5, 0);
        add_vec(0, 4'd5,  16'h0000, 16'h0000, 0);
        add_vec(0, 4'd1,  16'h0000, 16'h0000, 0);
        add_vec(1, 4'd0,  16'h1111, 16'h0000, 0);
        add_vec(1, 4'd1,  16'h2222, 16'h0000, 0);
        add_vec(0, 4'd0,  16'h0000, 16'h1111, 0);
        add_vec(0, 4'd1,  16'h0000, 16'h2222, 0);
        add_vec(0, 4'd11, 16'h0000, 16'h0000, 0);
        add_vec(1, 4'd11, 16'hCAFE, 16'h0000, 0);
        add_vec(0, 4'd11, 16'h0000, 16'hCAFE, 0);
        add_vec(1, 4'd12, 16'hBAD0, 16'h0000, 1);
        add_vec(0, 4'd15, 16'h0000, 16'h0000, 1);
        add_vec(0, 4'd0,  16'h0000, 16'h1111, 0);

        prst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
        #1;
        chk("reset_pready",  {31'b0, pready},  32'd0);
        chk("reset_pslverr", {31'b0, pslverr}, 32'd0);
        chk("reset_prdata",  {16'b0, prdata},  32'd0);
        repeat (3) @(posedge pclk);
        @(negedge pclk);
        prst = 1'b0;
        @(posedge pclk); #1;

        // Table: every transfer is issued back-to-back with the previous one.
        for (int i = 0; i < vecs.size(); i++) begin
            xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, 0, 0, rd, er, lat);
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'(WAIT + 1));
            chk($sformatf("v%0d_pslverr", i), {31'b0, er}, {31'b0, vecs[i].exp_err});
            if (!vecs[i].wr)
                chk($sformatf("v%0d_prdata", i), {16'b0, rd}, {16'b0, vecs[i].exp_rdata});
        end
        chk("prdata_holds_idle", {16'b0, prdata}, 32'h1111);

        // Abort: psel dropped at the edge where the write would have completed.
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 4'd2; pwdata = 16'hBEEF;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0;
        seen = 0;
        repeat (4) begin
            @(posedge pclk); #1;
            if (pready) seen++;
        end
        chk("abort_no_pready", 32'(seen), 32'd0);
        xfer(0, 4'd2, 16'h0, 0, 0, rd, er, lat);
        chk("abort_read_2", {16'b0, rd}, 32'h0000);

        // Hold with penable=0, and paddr/pwdata/pwrite changed after SETUP.
        xfer(1, 4'd6, 16'h1234, 3, 1, rd, er, lat);
        chk("hold_latency", 32'(lat), 32'(3 + WAIT + 1));
        chk("hold_pslverr", {31'b0, er}, 32'd0);
        xfer(0, 4'd6, 16'h0, 0, 0, rd, er, lat);
        chk("latched_read_6", {16'b0, rd}, 32'h1234);
        xfer(0, 4'd7, 16'h0, 0, 0, rd, er, lat);
        chk("ignored_read_7", {16'b0, rd}, 32'h0000);

        // Reset asserted mid-ACCESS while prdata holds a nonzero value.
        xfer(1, 4'd4, 16'h7777, 0, 0, rd, er, lat);
        xfer(0, 4'd4, 16'h0, 0, 0, rd, er, lat);
        chk("pre_reset_read_4", {16'b0, rd}, 32'h7777);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 4'd4; pwdata = 16'h8888;
        @(posedge pclk); #1;
        penable = 1'b1;
        #3 prst = 1'b1;
        #1;
        chk("midreset_pready",  {31'b0, pready},  32'd0);
        chk("midreset_pslverr", {31'b0, pslverr}, 32'd0);
        chk("midreset_prdata",  {16'b0, prdata},  32'd0);
        psel = 1'b0; penable = 1'b0;
        @(negedge pclk);
        prst = 1'b0;
        @(posedge pclk); #1;
        xfer(0, 4'd4, 16'h0, 0, 0, rd, er, lat);
        chk("post_reset_read_4", {16'b0, rd}, 32'h0000);
        xfer(0, 4'd0, 16'h0, 0, 0, rd, er, lat);
        chk("post_reset_read_0", {16'b0, rd}, 32'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
